// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a small multicycle datapath. Each instruction walks through
// FETCH -> DECODE -> EXEC [-> MEM] [-> WB], and the FSM raises the datapath
// enables and selects for each step. The opcode is decoded from an internal
// instruction register (IR) that is loaded at the end of FETCH.
//
// Optional feature (build macro MULTICYCLE_CTRL_PERF_CNT_EN):
//   defined   - instr_count is a 16-bit wrapping count of retired instructions
//   undefined - no counter; instr_count is tied to 0
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   instr        in  32   instruction word: op[31:28] rs[27:24] rt[23:20]
//                         rd[19:16] imm[15:0]
//   zero         in   1   ALU zero flag (sampled for BEQ in EXEC)
//   EnIM         out  1   instruction-memory enable
//   pc_en        out  1   PC <= PC+4
//   branch_take  out  1   PC <= branch target (one-cycle pulse)
//   EnRW         out  1   register-file write enable
//   wn           out  4   register-file write address
//   ALUsrc       out  1   1 = sign-extended imm, 0 = rt data
//   ALUctrl      out  3   000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   memread      out  1   data-memory read enable
//   memwrite     out  1   data-memory write enable
//   MemtoReg     out  1   1 = ALU result to register file, 0 = memory data
//   illegal_op   out  1   one-cycle pulse on an undefined opcode
//   halted       out  1   high while in HALT
//   state        out  3   current state code (debug)
//   instr_count  out 16   retired-instruction count (see macro above)
// -----------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        EnIM,
  output logic        pc_en,
  output logic        branch_take,
  output logic        EnRW,
  output logic [3:0]  wn,
  output logic        ALUsrc,
  output logic [2:0]  ALUctrl,
  output logic        memread,
  output logic        memwrite,
  output logic        MemtoReg,
  output logic        illegal_op,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h3;
  localparam logic [3:0] OP_SW   = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic        r_run;

  // ---------------------------------------------------------------------------
  // Decode from IR only; instr is looked at exclusively in FETCH.
  // ---------------------------------------------------------------------------
  logic [3:0] w_op;
  logic [3:0] w_rt;
  logic [3:0] w_rd;
  logic       w_rtype;
  logic       w_addi;
  logic       w_lw;
  logic       w_sw;
  logic       w_beq;
  logic       w_halt;
  logic       w_legal;
  logic [2:0] w_alu_ctrl;
  logic       w_alu_src;
  logic [3:0] w_wn;
  logic       w_unused_ir;

  assign w_op    = r_ir[31:28];
  assign w_rt    = r_ir[23:20];
  assign w_rd    = r_ir[19:16];
  assign w_rtype = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) ||
                   (w_op == OP_OR)  || (w_op == OP_SLT);
  assign w_addi  = (w_op == OP_ADDI);
  assign w_lw    = (w_op == OP_LW);
  assign w_sw    = (w_op == OP_SW);
  assign w_beq   = (w_op == OP_BEQ);
  assign w_halt  = (w_op == OP_HALT);
  assign w_legal = w_rtype || w_addi || w_lw || w_sw || w_beq;

  // rs and imm feed the datapath directly, never the controller.
  assign w_unused_ir = ^{r_ir[27:24], r_ir[15:0]};

  always_comb begin
    unique case (w_op)
      OP_SUB, OP_BEQ: w_alu_ctrl = 3'b110;
      OP_AND:         w_alu_ctrl = 3'b000;
      OP_OR:          w_alu_ctrl = 3'b001;
      OP_SLT:         w_alu_ctrl = 3'b111;
      default:        w_alu_ctrl = 3'b010;  // ADD, ADDI, LW, SW
    endcase
  end

  assign w_alu_src = w_addi || w_lw || w_sw;
  // Instructions that write no register (SW, BEQ) present address 0.
  assign w_wn      = w_rtype ? w_rd : ((w_addi || w_lw) ? w_rt : 4'd0);

  // ---------------------------------------------------------------------------
  // Sequential state. r_run holds IDLE for one extra edge after reset release
  // so the first FETCH lands on the second rising edge.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
      if (r_state == S_FETCH) r_ir <= instr;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs. Outputs are decoded from r_state alone, so an
  // asynchronous reset drops every enable in the same instant it hits IDLE.
  // Selects (ALUctrl, ALUsrc, wn) are held for all of EXEC, MEM and WB.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    w_next      = r_state;
    EnIM        = 1'b0;
    pc_en       = 1'b0;
    branch_take = 1'b0;
    EnRW        = 1'b0;
    wn          = 4'd0;
    ALUsrc      = 1'b0;
    ALUctrl     = 3'b000;
    memread     = 1'b0;
    memwrite    = 1'b0;
    MemtoReg    = 1'b0;
    illegal_op  = 1'b0;
    halted      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_run) w_next = S_FETCH;
      end
      S_FETCH: begin
        EnIM   = 1'b1;
        pc_en  = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next = S_EXEC;
        end else if (w_halt) begin
          w_next = S_HALT;
        end else begin
          illegal_op = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUctrl     = w_alu_ctrl;
        ALUsrc      = w_alu_src;
        wn          = w_wn;
        branch_take = w_beq && zero;
        if (w_lw || w_sw) w_next = S_MEM;
        else if (w_beq)   w_next = S_FETCH;
        else              w_next = S_WB;
      end
      S_MEM: begin
        ALUctrl  = w_alu_ctrl;
        ALUsrc   = w_alu_src;
        wn       = w_wn;
        memread  = w_lw;
        memwrite = w_sw;
        w_next   = w_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        ALUctrl  = w_alu_ctrl;
        ALUsrc   = w_alu_src;
        wn       = w_wn;
        EnRW     = 1'b1;
        memread  = w_lw;
        MemtoReg = !w_lw;
        w_next   = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign state = r_state;

  // ---------------------------------------------------------------------------
  // Retired-instruction counter: one tick per WB exit, SW MEM exit and
  // BEQ EXEC exit. Free-running 16-bit wrap.
  // ---------------------------------------------------------------------------
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [15:0] r_instr_count;
  logic        w_retire;

  assign w_retire = (r_state == S_WB) ||
                    ((r_state == S_MEM)  && w_sw) ||
                    ((r_state == S_EXEC) && w_beq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instr_count <= '0;
    else if (w_retire) r_instr_count <= r_instr_count + 16'd1;
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = 16'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Scoreboard bench. The stimulus process pushes one expected output snapshot
// per cycle of each instruction, then drives the instruction word. A separate
// monitor pops a snapshot every falling edge while entries are pending and
// compares it against the DUT. Reset behaviour and the retire counter are
// checked directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        EnIM;
  logic        pc_en;
  logic        branch_take;
  logic        EnRW;
  logic [3:0]  wn;
  logic        ALUsrc;
  logic [2:0]  ALUctrl;
  logic        memread;
  logic        memwrite;
  logic        MemtoReg;
  logic        illegal_op;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] instr_count;

  multicycle_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .zero        (zero),
    .EnIM        (EnIM),
    .pc_en       (pc_en),
    .branch_take (branch_take),
    .EnRW        (EnRW),
    .wn          (wn),
    .ALUsrc      (ALUsrc),
    .ALUctrl     (ALUctrl),
    .memread     (memread),
    .memwrite    (memwrite),
    .MemtoReg    (MemtoReg),
    .illegal_op  (illegal_op),
    .halted      (halted),
    .state       (state),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  typedef struct {
    string       tag;
    logic [19:0] v;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Snapshot layout: state, EnIM, pc_en, branch_take, EnRW, wn, ALUsrc,
  // ALUctrl, memread, memwrite, MemtoReg, illegal_op, halted.
  function automatic logic [19:0] mk(input int st, input int im, input int pc,
                                     input int bt, input int rw, input int w,
                                     input int src, input int ctl, input int mr,
                                     input int mw, input int m2r, input int ill,
                                     input int hlt);
    return {st[2:0], im[0], pc[0], bt[0], rw[0], w[3:0], src[0], ctl[2:0],
            mr[0], mw[0], m2r[0], ill[0], hlt[0]};
  endfunction

  task automatic push(input string tag, input logic [19:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic push_fd(input string tag);
    push({tag, "_fetch"},  mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push({tag, "_decode"}, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Called one time unit after the edge that entered FETCH; returns at the
  // same point of the next FETCH, n cycles later.
  task automatic go(input logic [31:0] ins, input logic z, input int n, input bit retires);
    instr = ins;
    zero  = z;
    repeat (n) @(posedge clk);
    #1;
    if (retires) exp_cnt++;
  endtask

  // R-type: FETCH, DECODE, EXEC, WB.
  task automatic r_type(input string tag, input logic [31:0] ins, input int rd, input int ctl);
    push_fd(tag);
    push({tag, "_exec"}, mk(3, 0, 0, 0, 0, rd, 0, ctl, 0, 0, 0, 0, 0));
    push({tag, "_wb"},   mk(5, 0, 0, 0, 1, rd, 0, ctl, 0, 0, 1, 0, 0));
    go(ins, 1'b0, 4, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(e.tag,
            32'({state, EnIM, pc_en, branch_take, EnRW, wn, ALUsrc, ALUctrl,
                 memread, memwrite, MemtoReg, illegal_op, halted}),
            32'(e.v));
    end
  end

  function automatic logic [31:0] cnt_req(input int n);
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    return 32'(n);
`else
    return 32'(0 * n);
`endif
  endfunction

  initial begin
    rst_n = 1'b1;
    instr = 32'h0123_0000;
    zero  = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    check("reset_state",  32'(state), 32'd0);
    check("reset_enables", 32'({EnIM, pc_en, branch_take, EnRW, memread, memwrite, illegal_op, halted}), 32'd0);
    check("reset_count",  32'(instr_count), 32'd0);

    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_edge1_idle", 32'(state), 32'd0);
    @(posedge clk); #1;
    check("post_reset_edge2_fetch", 32'(state), 32'd1);

    // ADD r3 = r1 + r2
    r_type("add", 32'h0123_0000, 3, 3'b010);

    // ADDI r1 = r4 + 7
    push_fd("addi");
    push("addi_exec", mk(3, 0, 0, 0, 0, 1, 1, 3'b010, 0, 0, 0, 0, 0));
    push("addi_wb",   mk(5, 0, 0, 0, 1, 1, 1, 3'b010, 0, 0, 1, 0, 0));
    go(32'h1410_0007, 1'b0, 4, 1'b1);

    // LW r4 = mem[r5 + 0x1234]
    push_fd("lw");
    push("lw_exec", mk(3, 0, 0, 0, 0, 4, 1, 3'b010, 0, 0, 0, 0, 0));
    push("lw_mem",  mk(4, 0, 0, 0, 0, 4, 1, 3'b010, 1, 0, 0, 0, 0));
    push("lw_wb",   mk(5, 0, 0, 0, 1, 4, 1, 3'b010, 1, 0, 0, 0, 0));
    go(32'h3540_1234, 1'b0, 5, 1'b1);

    // SW mem[r5 + 0x10] = r6
    push_fd("sw");
    push("sw_exec", mk(3, 0, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0, 0, 0));
    push("sw_mem",  mk(4, 0, 0, 0, 0, 0, 1, 3'b010, 0, 1, 0, 0, 0));
    go(32'h4560_0010, 1'b0, 4, 1'b1);

    // BEQ taken, then not taken
    push_fd("beq_z1");
    push("beq_z1_exec", mk(3, 0, 0, 1, 0, 0, 0, 3'b110, 0, 0, 0, 0, 0));
    go(32'h8120_0004, 1'b1, 3, 1'b1);
    push_fd("beq_z0");
    push("beq_z0_exec", mk(3, 0, 0, 0, 0, 0, 0, 3'b110, 0, 0, 0, 0, 0));
    go(32'h8120_0004, 1'b0, 3, 1'b1);

    // Remaining R-type ALU encodings
    r_type("sub", 32'h2ABC_0000, 12, 3'b110);
    r_type("and", 32'h5123_0000, 3,  3'b000);
    r_type("or",  32'h6456_0000, 6,  3'b001);
    r_type("slt", 32'h7789_0000, 9,  3'b111);

    // Undefined opcode: pulse in DECODE, straight back to FETCH
    push("ill_fetch",  mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("ill_decode", mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    go(32'hB000_0000, 1'b0, 2, 1'b0);

    // HALT: terminal, enables low, halted high
    push_fd("halt");
    for (int i = 0; i < 22; i++) push("halt_hold", mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    go(32'hFA98_0000, 1'b0, 24, 1'b0);

    check("count_after_program", 32'(instr_count), cnt_req(exp_cnt));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Reset out of HALT, three ADDs, then reset in the middle of a WB.
    #2 rst_n = 1'b0;
    #1;
    check("halt_reset_state", 32'(state), 32'd0);
    check("halt_reset_halted", 32'(halted), 32'd0);
    instr = 32'h0123_0000;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("rerun_fetch", 32'(state), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check("three_adds_fetch", 32'(state), 32'd1);
    check("three_adds_count", 32'(instr_count), cnt_req(3));
    repeat (3) @(posedge clk);
    #1;
    check("abort_in_wb_state", 32'(state), 32'd5);
    check("abort_in_wb_enrw", 32'(EnRW), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_enrw_low", 32'(EnRW), 32'd0);
    check("abort_state_idle", 32'(state), 32'd0);
    check("abort_count_clear", 32'(instr_count), 32'd0);
    @(posedge clk); #1;
    check("abort_no_write_after", 32'({EnRW, memwrite, branch_take}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 clk  in  1  system clock; all state changes occur on the rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 instr  in  32  instruction word from instruction memory; fields op=[31:28], rs=[27:24], rt=[23:20], rd=[19:16], imm=[15:0].
REQ-005 zero  in  1  ALU zero flag.
REQ-006 EnIM  out  1  instruction-memory enable.
REQ-007 pc_en  out  1  PC register load of PC+4.
REQ-008 branch_take  out  1  PC load of the branch target, one-cycle pulse.
REQ-009 EnRW  out  1  register-file write enable.
REQ-010 wn  out  4  register-file write address.
REQ-011 ALUsrc  out  1  1 = sign-extended imm, 0 = rt data.
REQ-012 ALUctrl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-013 memread / memwrite  out  1 each  data-memory read / write enables.
REQ-014 MemtoReg  out  1  1 = ALU result to register file, 0 = memory data.
REQ-015 illegal_op  out  1  one-cycle pulse on an undefined opcode.
REQ-016 halted  out  1  high while in HALT.
REQ-017 state  out  3  current state code, for debug.
REQ-018 instr_count  out  16  retired-instruction count; see Configuration.

Function
REQ-019 States and codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; codes 7 and up go to IDLE.
REQ-020 IDLE: all outputs 0; next state is FETCH.
REQ-021 FETCH: EnIM=1 and pc_en=1; the internal IR captures instr at the cycle end; next state is DECODE.
REQ-022 DECODE decodes the opcode from IR only.
- op 0 ADD, 2 SUB, 5 AND, 6 OR, 7 SLT (R-type); 1 ADDI; 3 LW; 4 SW; 8 BEQ: go to EXEC.
- op F: go to HALT.
- Any other op: pulse illegal_op and return to FETCH, no side effects.
REQ-023 EXEC sets ALUctrl per opcode; ADDI, LW and SW use ALU ADD; BEQ uses SUB.
- ALUsrc=1 for ADDI, LW and SW; otherwise 0.
- Next state: R-type and ADDI go to WB; LW and SW go to MEM; BEQ goes to FETCH.
REQ-024 BEQ in EXEC: branch_take equals zero for that single cycle.
REQ-025 MEM with LW: memread=1, then WB. MEM with SW: memwrite=1 for exactly one cycle, then FETCH.
REQ-026 WB: EnRW=1 for exactly one cycle.
- wn=rd for R-type; wn=rt for ADDI and LW.
- MemtoReg=0 and memread=1 held for LW; MemtoReg=1 otherwise.
- Next state is FETCH.
REQ-027 ALUctrl, ALUsrc and wn SHALL stay stable from EXEC through WB of the same instruction.
REQ-028 Latency in cycles, from FETCH to the next FETCH: R/ADDI 4, LW 5, SW 4, BEQ 3, illegal 2.
REQ-029 HALT is terminal: all enables 0, halted=1; only rst_n exits.
REQ-030 EnRW, memwrite and branch_take SHALL never be high in the same cycle.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE, IR=0 and instr_count=0, and drive all enables 0, independent of clk.
REQ-032 A reset mid-instruction (in any state) SHALL abort the instruction with no further write or branch pulse; the first FETCH occurs two rising edges after rst_n deasserts.

Configuration
REQ-033 Macro MULTICYCLE_CTRL_PERF_CNT_EN.
- Defined: instr_count increments by 1 on each WB exit, each SW MEM exit and each BEQ EXEC exit; it wraps 0xFFFF to 0x0000 and saturates nowhere.
- Undefined: the counter is absent and instr_count is tied to 0.

Verification
REQ-034 Reset, then instr=0x0123_0000 (ADD) -> states 1,2,3,5; ALUctrl=010, ALUsrc=0; WB: EnRW=1, wn=3, MemtoReg=1.
REQ-035 instr=0x1410_0007 (ADDI) -> EXEC: ALUsrc=1, ALUctrl=010; WB: wn=1, EnRW=1 for one cycle.
REQ-036 instr=0x3540_1234 (LW) -> MEM: memread=1; WB: memread=1, MemtoReg=0, wn=4; total 5 cycles.
REQ-037 BEQ (0x8120_0004) with zero=1 -> branch_take pulses one cycle in EXEC. With zero=0 -> no pulse; FETCH follows after 3 cycles.
REQ-038 instr=0xB000_0000 -> illegal_op pulses in DECODE, then FETCH. instr=0xFA98_0000 -> HALT, halted=1, all enables 0 for 20+ cycles.
REQ-039 rst_n dropped during WB of an ADD -> EnRW falls to 0 asynchronously; state=0. With the macro defined, 3 completed ADDs give instr_count=3, and reset clears it to 0.
